// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: valid/ready channel bundle between N producers, the arbiter mux, and one consumer.
interface rr_arb_mux_if #(
    parameter int N = 8,
    parameter int WIDTH = 8,
    localparam int SELW = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel registered mux with round-robin arbitration and valid/ready handshakes.
// Defining RR_MUX_LOCK_EN holds the grant on one channel until its in_last beat is accepted.
module rr_arb_mux #(
    parameter int N = 8,
    parameter int WIDTH = 8,
    localparam int SELW = $clog2(N)
) (
    input logic         clk,
    input logic         rst_n,
    rr_arb_mux_if.slave bus
);
    logic [SELW-1:0]  ptr, rr_g, g, g_nxt, idx;
    logic [WIDTH-1:0] g_data;
    logic             rr_hit, gv, load, acc, adv;
    // Scan downwards so the last hit written is the first channel at or after ptr.
    always_comb begin
        rr_g = ptr;
        rr_hit = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = SELW'((int'(ptr) + k) % N);
            if (bus.in_valid[idx]) begin
                rr_g = idx;
                rr_hit = 1'b1;
            end
        end
    end
`ifdef RR_MUX_LOCK_EN
    logic            lock;
    logic [SELW-1:0] lock_ch;
    assign g   = lock ? lock_ch : rr_g;
    assign gv  = lock ? bus.in_valid[lock_ch] : rr_hit;
    assign adv = acc && bus.in_last[g];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (acc) begin
            lock    <= !bus.in_last[g];
            lock_ch <= g;
        end
    end
`else
    assign g   = rr_g;
    assign gv  = rr_hit;
    assign adv = acc;
`endif
    assign load  = !bus.out_valid || bus.out_ready;
    assign acc   = rst_n && load && gv;
    assign g_nxt = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);
    always_comb begin
        g_data = '0;
        for (int k = 0; k < N; k++)
            if (SELW'(k) == g) g_data = bus.in_data[k*WIDTH +: WIDTH];
    end
    always_comb begin
        bus.in_ready = '0;
        bus.in_ready[g] = acc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (load) begin
            bus.out_valid <= gv;
            if (gv) begin
                bus.out_data <= g_data;
                bus.out_last <= bus.in_last[g];
                bus.out_sel  <= g;
            end
            if (adv) ptr <= g_nxt;
        end
    end
endmodule
